// File: rtl/i2s_adc_receiver.sv
// I2S capture for the WM8731 ADC path: codec-mastered BCLK/LRCK are oversampled in the Clk
// domain, each channel word is shifted in MSB first, and L/R pairs go out over valid/ready.
module i2s_adc_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  enable,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  output logic [DATA_WIDTH-1:0] left_sample,
  output logic [DATA_WIDTH-1:0] right_sample,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  output logic                  frame_err,
  input  logic                  clear_flags
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT} state_t;

  state_t                  state, state_d;
  logic [SYNC_STAGES-1:0]  bclk_sync, lrck_sync, dat_sync;
  logic                    bclk_s, lrck_s, dat_s;
  logic                    bclk_q, lrck_prev;
  logic                    bclk_rise, lr_chg;
  logic [CNT_W-1:0]        cnt;
  logic                    ch;
  logic                    left_ok;
  logic                    pair_done;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
  logic [DATA_WIDTH-1:0]   left_buf, right_buf;
  logic                    start_word, shift_en, word_done, frame_abort;
  logic                    ovr_set;

  assign bclk_s     = bclk_sync[SYNC_STAGES-1];
  assign lrck_s     = lrck_sync[SYNC_STAGES-1];
  assign dat_s      = dat_sync[SYNC_STAGES-1];
  assign bclk_rise  = bclk_s & ~bclk_q;
  assign lr_chg     = lrck_s ^ lrck_prev;
  assign shift_next = {shift_reg[DATA_WIDTH-2:0], dat_s};
  assign ovr_set    = pair_done & sample_valid & ~sample_ready;

  // All three pins share the same synchroniser depth so data and LRCK line up with bclk_rise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_q    <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_ADCLRCK};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], AUD_ADCDAT};
      bclk_q    <= bclk_s;
      if (bclk_rise) lrck_prev <= lrck_s;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  // The bit on which LRCK changes is the I2S delay slot, so it only starts a word.
  always_comb begin
    state_d     = state;
    start_word  = 1'b0;
    shift_en    = 1'b0;
    word_done   = 1'b0;
    frame_abort = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else if (bclk_rise) begin
      case (state)
        S_IDLE: begin
          if (lr_chg && !lrck_s) begin
            state_d    = S_SHIFT;
            start_word = 1'b1;
          end
        end
        S_SHIFT: begin
          if (lr_chg) begin
            frame_abort = 1'b1;
            if (!lrck_s) begin
              state_d    = S_SHIFT;
              start_word = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            shift_en = 1'b1;
            if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
              word_done = 1'b1;
              state_d   = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (lr_chg) begin
            state_d    = S_SHIFT;
            start_word = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt       <= '0;
      ch        <= 1'b0;
      shift_reg <= '0;
      left_buf  <= '0;
      right_buf <= '0;
      left_ok   <= 1'b0;
      pair_done <= 1'b0;
    end else begin
      pair_done <= 1'b0;
      if (start_word) begin
        cnt <= '0;
        ch  <= lrck_s;
      end
      if (shift_en) begin
        shift_reg <= shift_next;
        cnt       <= cnt + CNT_W'(1);
      end
      if (word_done) begin
        if (!ch) begin
          left_buf <= shift_next;
          left_ok  <= 1'b1;
        end else begin
          right_buf <= shift_next;
          if (left_ok) begin
            pair_done <= 1'b1;
            left_ok   <= 1'b0;
          end
        end
      end
      if (frame_abort || !enable) left_ok <= 1'b0;
    end
  end

  // One-deep holding register; a consumer taking the old pair makes room in the same cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      if (pair_done) begin
        if (!sample_valid || sample_ready) begin
          left_sample  <= left_buf;
          right_sample <= right_buf;
          sample_valid <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      overrun   <= (overrun & ~clear_flags) | ovr_set;
      frame_err <= (frame_err & ~clear_flags) | frame_abort;
    end
  end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver: drives I2S frames bit by bit, scoreboards expected
// L/R pairs and compares them whenever the DUT hands a pair over.
module tb_i2s_adc_receiver;

  localparam int DW = 16;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          enable;
  logic          AUD_BCLK;
  logic          AUD_ADCLRCK;
  logic          AUD_ADCDAT;
  logic [DW-1:0] left_sample;
  logic [DW-1:0] right_sample;
  logic          sample_valid;
  logic          sample_ready;
  logic          overrun;
  logic          frame_err;
  logic          clear_flags;

  int            checks     = 0;
  int            errors     = 0;
  int            pairs_seen = 0;
  logic [31:0]   sb_q[$];

  always #5 Clk = ~Clk;

  i2s_adc_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .enable       (enable),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_ADCLRCK  (AUD_ADCLRCK),
    .AUD_ADCDAT   (AUD_ADCDAT),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .frame_err    (frame_err),
    .clear_flags  (clear_flags)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One BCLK period of 8 Clk; inputs change 2 ns after a Clk rise.
  // mode 1 pulses ready on the cycle the completed pair reaches the holding register,
  // mode 2 checks that valid rises exactly SYNC_STAGES+2 Clk after the BCLK rise.
  task automatic applyStimulus(input logic lr, input logic d, input int mode);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = lr;
    AUD_ADCDAT  = d;
    repeat (4) begin
      @(posedge Clk);
      #2;
    end
    AUD_BCLK = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      #2;
      if (mode == 1 && i == 2) sample_ready = 1'b1;
      if (mode == 1 && i == 3) sample_ready = 1'b0;
      if (mode == 2 && i == 2) checkOutput("latency_not_yet", {31'd0, sample_valid}, 32'd0);
      if (mode == 2 && i == 3) checkOutput("latency_valid", {31'd0, sample_valid}, 32'd1);
    end
  endtask

  task automatic sendBits(input logic lr, input logic [DW-1:0] word, input int hi, input int lo,
                          input int last_mode);
    for (int b = hi; b >= lo; b--) applyStimulus(lr, word[b], (b == lo) ? last_mode : 0);
  endtask

  task automatic pad(input logic lr, input int n);
    for (int k = 0; k < n; k++) applyStimulus(lr, 1'b0, 0);
  endtask

  // 32 BCLK per channel: delay slot, DW data bits MSB first, then zero padding.
  task automatic sendChannel(input logic lr, input logic [DW-1:0] word, input int last_mode);
    applyStimulus(lr, 1'b0, 0);
    sendBits(lr, word, DW - 1, 0, last_mode);
    pad(lr, 31 - DW);
  endtask

  task automatic sendFrame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit expect_pair,
                           input int last_mode);
    sendChannel(1'b0, l, 0);
    if (expect_pair) sb_q.push_back({l, r});
    sendChannel(1'b1, r, last_mode);
  endtask

  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && sample_valid === 1'b1 && sample_ready === 1'b1) begin
      pairs_seen++;
      checks++;
      assert (sb_q.size() != 0)
      else begin
        errors++;
        $error("[TB] FAIL unexpected_pair: observed %0h/%0h expected none", left_sample, right_sample);
      end
      if (sb_q.size() != 0) checkOutput("pair_data", {left_sample, right_sample}, sb_q.pop_front());
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset_n      = 1'b0;
    enable       = 1'b0;
    AUD_BCLK     = 1'b0;
    AUD_ADCLRCK  = 1'b0;
    AUD_ADCDAT   = 1'b0;
    sample_ready = 1'b0;
    clear_flags  = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    checkOutput("rst_valid", {31'd0, sample_valid}, 32'd0);
    checkOutput("rst_samples", {left_sample, right_sample}, 32'd0);
    checkOutput("rst_flags", {30'd0, overrun, frame_err}, 32'd0);

    Reset_n      = 1'b1;
    enable       = 1'b1;
    sample_ready = 1'b1;
    pad(1'b1, 4);

    $display("[TB] basic frame");
    sendFrame(16'hA5C3, 16'h1234, 1'b1, 2);
    checkOutput("t1_pairs", pairs_seen, 32'd1);
    checkOutput("t1_held", {left_sample, right_sample}, 32'hA5C3_1234);
    checkOutput("t1_flags", {30'd0, overrun, frame_err}, 32'd0);

    $display("[TB] overrun with stalled consumer");
    sample_ready = 1'b0;
    sendFrame(16'h0001, 16'h0002, 1'b1, 0);
    sendFrame(16'h0003, 16'h0004, 1'b0, 0);
    sendFrame(16'h0005, 16'h0006, 1'b0, 0);
    checkOutput("t2_valid_held", {31'd0, sample_valid}, 32'd1);
    checkOutput("t2_held", {left_sample, right_sample}, 32'h0001_0002);
    checkOutput("t2_overrun", {31'd0, overrun}, 32'd1);
    sample_ready = 1'b1;
    @(posedge Clk);
    #2;
    checkOutput("t2_valid_drop", {31'd0, sample_valid}, 32'd0);
    checkOutput("t2_pairs", pairs_seen, 32'd2);
    clear_flags = 1'b1;
    @(posedge Clk);
    #2;
    clear_flags = 1'b0;
    checkOutput("t2_overrun_clr", {31'd0, overrun}, 32'd0);

    $display("[TB] ready in the same cycle as a new pair");
    sample_ready = 1'b0;
    sendFrame(16'h0A0A, 16'h0B0B, 1'b1, 0);
    checkOutput("t5_first_held", {31'd0, sample_valid}, 32'd1);
    sendFrame(16'hC0DE, 16'hBEEF, 1'b1, 1);
    checkOutput("t5_valid_stays", {31'd0, sample_valid}, 32'd1);
    checkOutput("t5_no_overrun", {31'd0, overrun}, 32'd0);
    checkOutput("t5_new_held", {left_sample, right_sample}, 32'hC0DE_BEEF);
    checkOutput("t5_pairs_mid", pairs_seen, 32'd3);
    sample_ready = 1'b1;
    @(posedge Clk);
    #2;
    checkOutput("t5_valid_drop", {31'd0, sample_valid}, 32'd0);
    checkOutput("t5_pairs", pairs_seen, 32'd4);

    $display("[TB] early LRCK change");
    applyStimulus(1'b0, 1'b0, 0);
    sendBits(1'b0, 16'h6789, DW - 1, DW - 8, 0);
    sendChannel(1'b1, 16'h5555, 0);
    checkOutput("t4_frame_err", {31'd0, frame_err}, 32'd1);
    checkOutput("t4_no_pair", pairs_seen, 32'd4);
    sendFrame(16'h8000, 16'h7FFF, 1'b1, 0);
    checkOutput("t4_pairs", pairs_seen, 32'd5);
    checkOutput("t4_held", {left_sample, right_sample}, 32'h8000_7FFF);
    clear_flags = 1'b1;
    @(posedge Clk);
    #2;
    clear_flags = 1'b0;
    checkOutput("t4_frame_err_clr", {31'd0, frame_err}, 32'd0);

    $display("[TB] enable dropped mid word");
    applyStimulus(1'b0, 1'b0, 0);
    sendBits(1'b0, 16'h9999, DW - 1, DW - 8, 0);
    enable = 1'b0;
    sendBits(1'b0, 16'h9999, DW - 9, 0, 0);
    pad(1'b0, 31 - DW);
    enable = 1'b1;
    sendChannel(1'b1, 16'h4444, 0);
    checkOutput("t6_no_pair", pairs_seen, 32'd5);
    checkOutput("t6_no_frame_err", {31'd0, frame_err}, 32'd0);
    sendFrame(16'h1357, 16'h2468, 1'b1, 0);
    checkOutput("t6_pairs", pairs_seen, 32'd6);

    $display("[TB] reset mid right word");
    sendChannel(1'b0, 16'hDEAD, 0);
    applyStimulus(1'b1, 1'b0, 0);
    sendBits(1'b1, 16'hFACE, DW - 1, DW - 6, 0);
    Reset_n = 1'b0;
    sendBits(1'b1, 16'hFACE, DW - 7, DW - 8, 0);
    checkOutput("t3_rst_valid", {31'd0, sample_valid}, 32'd0);
    checkOutput("t3_rst_samples", {left_sample, right_sample}, 32'd0);
    Reset_n = 1'b1;
    sendBits(1'b1, 16'hFACE, DW - 9, 0, 0);
    pad(1'b1, 31 - DW);
    checkOutput("t3_no_pair", pairs_seen, 32'd6);
    sendFrame(16'hCAFE, 16'h0F0F, 1'b1, 0);
    checkOutput("t3_pairs", pairs_seen, 32'd7);
    checkOutput("t3_held", {left_sample, right_sample}, 32'hCAFE_0F0F);
    checkOutput("sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
